// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for a serial shift-register datapath: takes a parallel word over
// valid/ready, shifts it out LSB-first with a per-bit strobe, and captures the returning stream.
module shift_seq_ctrl #(
    parameter  int unsigned WIDTH = 6,
    parameter  int unsigned GAP   = 0,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic             abort_i,
    output logic             ser_out_o,
    output logic             shift_en_o,
    input  logic             cap_in_i,
    output logic [WIDTH-1:0] cap_data_o,
    output logic             cap_valid_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // The gap counter runs GAP-1 down to 0, giving exactly GAP idle cycles.
    localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] cap_sh_q;
    logic [WIDTH-1:0] cap_data_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [3:0]       gap_q;
    logic             ser_out_q;
    logic             shift_en_q;
    logic             cap_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] cap_sh_d;
    logic [CNT_W-1:0] bit_cnt_d;
    logic             last_bit;

    // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
    always_comb begin
        shreg_d   = {1'b0, shreg_q[WIDTH-1:1]};
        cap_sh_d  = {cap_in_i, cap_sh_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        last_bit  = (bit_cnt_q == LAST_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cap_sh_q    <= '0;
            cap_data_q  <= '0;
            bit_cnt_q   <= '0;
            gap_q       <= '0;
            ser_out_q   <= 1'b0;
            shift_en_q  <= 1'b0;
            cap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cap_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_valid_i) begin
                        state_q    <= ST_SHIFT;
                        shreg_q    <= load_data_i;
                        ser_out_q  <= load_data_i[0];
                        shift_en_q <= 1'b1;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= '0;
                    end
                end

                ST_SHIFT: begin
                    if (abort_i) begin
                        // Abort beats completion: the partial capture is discarded.
                        state_q    <= ST_IDLE;
                        ser_out_q  <= 1'b0;
                        shift_en_q <= 1'b0;
                        busy_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                    end else begin
                        shreg_q   <= shreg_d;
                        cap_sh_q  <= cap_sh_d;
                        bit_cnt_q <= bit_cnt_d;
                        if (last_bit) begin
                            cap_data_q  <= cap_sh_d;
                            cap_valid_q <= 1'b1;
                            ser_out_q   <= 1'b0;
                            shift_en_q  <= 1'b0;
                            if (GAP > 0) begin
                                state_q <= ST_GAP;
                                gap_q   <= GAP_LOAD;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            ser_out_q <= shreg_d[0];
                        end
                    end
                end

                ST_GAP: begin
                    if (abort_i) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                    end else if (gap_q == 4'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    ser_out_q  <= 1'b0;
                    shift_en_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Ready is the only combinational output so a handshake can complete in the IDLE cycle.
    assign load_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign ser_out_o    = ser_out_q;
    assign shift_en_o   = shift_en_q;
    assign cap_data_o   = cap_data_q;
    assign cap_valid_o  = cap_valid_q;
    assign busy_o       = busy_q;
    assign bit_cnt_o    = bit_cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (GAP=0 and GAP=3) against a timeline model that
// predicts every output from the cycle offset since the last accepted word.
module tb_shift_seq_ctrl;

    localparam int W  = 6;
    localparam int CW = $clog2(W) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rst, load_valid, abort, cap_in;
    logic [1:0][W-1:0]  load_data;
    logic [1:0]         load_ready, ser_out, shift_en, cap_valid, busy;
    logic [1:0][W-1:0]  cap_data;
    logic [1:0][CW-1:0] bit_cnt;

    shift_seq_ctrl #(.WIDTH(W), .GAP(0)) u_g0 (
        .clk_i(clk), .rst_i(rst[0]), .load_data_i(load_data[0]), .load_valid_i(load_valid[0]),
        .load_ready_o(load_ready[0]), .abort_i(abort[0]), .ser_out_o(ser_out[0]),
        .shift_en_o(shift_en[0]), .cap_in_i(cap_in[0]), .cap_data_o(cap_data[0]),
        .cap_valid_o(cap_valid[0]), .busy_o(busy[0]), .bit_cnt_o(bit_cnt[0])
    );

    shift_seq_ctrl #(.WIDTH(W), .GAP(3)) u_g3 (
        .clk_i(clk), .rst_i(rst[1]), .load_data_i(load_data[1]), .load_valid_i(load_valid[1]),
        .load_ready_o(load_ready[1]), .abort_i(abort[1]), .ser_out_o(ser_out[1]),
        .shift_en_o(shift_en[1]), .cap_in_i(cap_in[1]), .cap_data_o(cap_data[1]),
        .cap_valid_o(cap_valid[1]), .busy_o(busy[1]), .bit_cnt_o(bit_cnt[1])
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Timeline model: while act, the current cycle is k+d for the handshake at edge k.
    int         gapv [2] = '{0, 3};
    bit         act  [2];
    int         d    [2];
    int         bcnt [2];
    bit         cv   [2];
    logic [W-1:0] word [2];
    logic [W-1:0] samp [2];
    logic [W-1:0] ecap [2];

    bit   lb_en = 1'b0;
    logic prev_ser [2];
    int   se_cnt [2];
    int   cv_cnt [2];
    int   hs_cyc [2][$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_update(input int x);
        if (rst[x]) begin
            act[x] = 0; bcnt[x] = 0; cv[x] = 0; ecap[x] = '0;
        end else if (act[x]) begin
            cv[x] = 0;
            if (abort[x]) begin
                act[x] = 0; bcnt[x] = 0;
            end else if (d[x] <= W) begin
                samp[x][d[x]-1] = cap_in[x];
                if (d[x] == W) begin
                    ecap[x] = samp[x]; cv[x] = 1; bcnt[x] = W;
                    if (gapv[x] == 0) act[x] = 0;
                end
                d[x]++;
            end else begin
                d[x]++;
                if (d[x] > W + gapv[x]) act[x] = 0;
            end
        end else begin
            cv[x] = 0;
            if (load_valid[x]) begin
                act[x] = 1; d[x] = 1; word[x] = load_data[x]; bcnt[x] = 0;
            end
        end
    endtask

    task automatic compare(input int x);
        string p;
        logic e_se, e_ser, e_busy, e_rdy;
        int   e_bc;
        p = (x == 0) ? "g0" : "g3";
        if (act[x]) begin
            e_rdy  = 1'b0;
            e_busy = 1'b1;
            if (d[x] <= W) begin
                e_se = 1'b1; e_ser = word[x][d[x]-1]; e_bc = d[x] - 1;
            end else begin
                e_se = 1'b0; e_ser = 1'b0; e_bc = W;
            end
        end else begin
            e_rdy = !rst[x]; e_busy = 1'b0; e_se = 1'b0; e_ser = 1'b0; e_bc = bcnt[x];
        end
        check({p, " load_ready"}, 32'(load_ready[x]), 32'(e_rdy));
        check({p, " busy"},       32'(busy[x]),       32'(e_busy));
        check({p, " shift_en"},   32'(shift_en[x]),   32'(e_se));
        check({p, " ser_out"},    32'(ser_out[x]),    32'(e_ser));
        check({p, " bit_cnt"},    32'(bit_cnt[x]),    32'(e_bc));
        check({p, " cap_valid"},  32'(cap_valid[x]),  32'(cv[x]));
        check({p, " cap_data"},   32'(cap_data[x]),   32'(ecap[x]));
        if (shift_en[x] === 1'b1)  se_cnt[x]++;
        if (cap_valid[x] === 1'b1) cv_cnt[x]++;
    endtask

    task automatic tick();
        for (int x = 0; x < 2; x++) begin
            if (load_valid[x] && load_ready[x]) hs_cyc[x].push_back(cyc);
            model_update(x);
        end
        @(negedge clk);
        cyc++;
        for (int x = 0; x < 2; x++) begin
            compare(x);
            if (lb_en) begin
                cap_in[x]   = prev_ser[x];
                prev_ser[x] = ser_out[x];
            end
        end
    endtask

    task automatic clear_counts();
        for (int x = 0; x < 2; x++) begin
            se_cnt[x] = 0; cv_cnt[x] = 0; hs_cyc[x].delete();
        end
    endtask

    task automatic load_both(input logic [W-1:0] v);
        load_data  = {v, v};
        load_valid = 2'b11;
        tick();
        load_valid = 2'b00;
    endtask

    initial begin
        rst = 2'b11; load_valid = '0; abort = '0; cap_in = '0; load_data = '0;
        for (int x = 0; x < 2; x++) begin
            act[x] = 0; d[x] = 0; bcnt[x] = 0; cv[x] = 0;
            word[x] = '0; samp[x] = '0; ecap[x] = '0; prev_ser[x] = 1'b0;
        end
        clear_counts();
        @(negedge clk);
        repeat (2) tick();
        rst = 2'b00;
        tick();

        // Loopback through a one-cycle delay: expect the word shifted up by one bit.
        lb_en = 1'b1;
        clear_counts();
        load_both(6'b101101);
        repeat (12) tick();
        check("basic cap_data", 32'(cap_data[0]), 32'h1A);
        check("basic shift_en count", 32'(se_cnt[0]), 32'd6);
        check("basic cap_valid count", 32'(cv_cnt[0]), 32'd1);
        lb_en = 1'b0;

        // Back-to-back words with valid held high on each instance.
        clear_counts();
        for (int n = 0; n < 100 && (hs_cyc[0].size() < 2 || hs_cyc[1].size() < 2); n++) begin
            for (int x = 0; x < 2; x++) begin
                load_valid[x] = (hs_cyc[x].size() < 2);
                load_data[x]  = (hs_cyc[x].size() == 0) ? 6'h15 : 6'h2A;
                cap_in[x]     = 1'($urandom_range(1));
            end
            tick();
        end
        load_valid = '0;
        repeat (12) tick();
        check("b2b g0 handshakes", 32'(hs_cyc[0].size()), 32'd2);
        check("b2b g3 handshakes", 32'(hs_cyc[1].size()), 32'd2);
        if (hs_cyc[0].size() == 2 && hs_cyc[1].size() == 2) begin
            check("b2b g0 spacing", 32'(hs_cyc[0][1] - hs_cyc[0][0]), 32'd7);
            check("g3 spacing", 32'(hs_cyc[1][1] - hs_cyc[1][0]), 32'd10);
        end
        check("b2b g0 shift_en count", 32'(se_cnt[0]), 32'd12);
        check("b2b g0 cap_valid count", 32'(cv_cnt[0]), 32'd2);
        check("b2b g3 cap_valid count", 32'(cv_cnt[1]), 32'd2);

        // Abort after three bits, then abort on the final shift cycle.
        for (int a = 3; a <= W - 1; a += W - 4) begin
            clear_counts();
            load_both(W'($urandom));
            repeat (a) tick();
            abort = 2'b11;
            tick();
            abort = 2'b00;
            check($sformatf("abort@%0d ready", a), 32'(load_ready[0]), 32'd1);
            check($sformatf("abort@%0d bit_cnt", a), 32'(bit_cnt[0]), 32'd0);
            repeat (3) tick();
            check($sformatf("abort@%0d cap_valid count", a), 32'(cv_cnt[0] + cv_cnt[1]), 32'd0);
        end

        // Mid-transfer reset, then a clean loopback transfer of all ones.
        load_both(6'h2C);
        repeat (3) tick();
        rst = 2'b11;
        repeat (2) tick();
        rst = 2'b00;
        lb_en = 1'b1;
        clear_counts();
        tick();
        load_both(6'h3F);
        repeat (12) tick();
        check("post-reset cap_data", 32'(cap_data[0]), 32'h3E);
        check("post-reset cap_valid count", 32'(cv_cnt[0]), 32'd1);
        lb_en = 1'b0;

        // Randomized traffic with occasional abort and reset.
        for (int n = 0; n < 3000; n++) begin
            for (int x = 0; x < 2; x++) begin
                rst[x]        = ($urandom_range(99) == 0);
                abort[x]      = ($urandom_range(15) == 0);
                load_valid[x] = 1'($urandom_range(1));
                load_data[x]  = W'($urandom);
                cap_in[x]     = 1'($urandom_range(1));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the 6-bit serial shift-register datapath. Accepts a parallel word over a valid/ready handshake, drives it LSB-first onto the datapath serial input with a per-bit shift enable, and captures the returning serial bit stream into a parallel word. Sits between the register-file/host side and the shift chain. Guarantees a programmable idle gap between words.

## Interface
- WIDTH, 6, bits per word / shift cycles per transfer (2..32)
- GAP, 0, idle cycles inserted after each transfer before the next word can be accepted (0..15)

- clk  in  1  rising-edge clock; sole clock
- rst  in  1  reset; synchronous, active-high
- load_data  in  WIDTH  parallel word to shift out
- load_valid  in  1  load_data valid
- load_ready  out  1  controller can accept a word
- abort  in  1  synchronous abort of the current transfer
- ser_out  out  1  serial bit to datapath x input
- shift_en  out  1  datapath shift strobe; one bit per high cycle
- cap_in  in  1  serial bit returned from the datapath
- cap_data  out  WIDTH  captured parallel word
- cap_valid  out  1  one-cycle pulse: cap_data updated
- busy  out  1  transfer or gap in progress
- bit_cnt  out  log2(WIDTH)+1  number of bits shifted in the current transfer

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: load_ready=1, shift_en=0, busy=0. load_valid & load_ready at a rising edge -> latch load_data into the shift register, clear bit_cnt, go to SHIFT.
- SHIFT: shift_en=1, ser_out=shreg[0], busy=1, load_ready=0. At each edge:
  - shreg shifts right by 1.
  - cap_in enters the capture register MSB and shifts toward the LSB, so the first bit received lands at cap_data[0] after WIDTH bits.
  - bit_cnt increments.
- After WIDTH SHIFT cycles: cap_data is updated, cap_valid pulses, and the FSM goes to GAP if GAP>0, otherwise to IDLE.
- GAP: busy=1, load_ready=0, shift_en=0. A down-counter is loaded with GAP-1; the FSM returns to IDLE when it reaches 0.
- abort is sampled in SHIFT or GAP. At the next edge:
  - go to IDLE;
  - no cap_valid, and cap_data keeps its previous value;
  - bit_cnt resets to 0.
  - abort in IDLE has no effect.
- abort has priority over a final-bit completion in the same cycle: no cap_valid.
- load_valid while not ready is ignored; no queuing. The source must hold the word until the handshake completes.
- ser_out=0 whenever shift_en=0.

## Timing
- Reset (rst high at an edge): the following take effect at that edge and hold while rst stays high:
  - state=IDLE;
  - ser_out=0, shift_en=0, cap_data=0, cap_valid=0, busy=0, bit_cnt=0;
  - internal shift, capture and gap registers are cleared.
- load_ready is combinational: (state==IDLE) & ~rst.
- rst asserted mid-transfer aborts the transfer, with no cap_valid.
- Handshake at edge k:
  - shift_en is high in cycles k+1 .. k+WIDTH.
  - ser_out in cycle k+1+i equals load_data[i].
  - cap_in is sampled at the end of each of those cycles.
  - cap_valid is high in cycle k+WIDTH+1, with cap_data valid from that cycle until the next cap_valid.
- GAP=0: load_ready is high in cycle k+WIDTH+1. Next-word throughput is WIDTH+1 cycles per word.
- GAP=G: load_ready is high in cycle k+WIDTH+1+G.
- bit_cnt equals the number of completed shifts; it reads WIDTH in the cycle after the last shift.
- All outputs except load_ready are registered.

## Test plan
- Basic transfer (WIDTH=6, GAP=0):
  - Stimulus: load 6'b101101; loop ser_out back into cap_in through a 1-cycle delay register.
  - Required: ser_out sequence 1,0,1,1,0,1 over 6 shift_en cycles; cap_valid exactly once.
  - Required: cap_data equals load_data shifted by the loop delay, i.e. 6'b011010 with an initial flop value of 0.
- Back-to-back words: load_valid held high with 6'h15 then 6'h2A.
  - Required: second handshake occurs in cycle k+7; second shift_en burst starts at k+8.
  - Required: exactly 12 shift_en cycles total, 2 cap_valid pulses.
- GAP=3: handshake at k.
  - Required: load_ready low for cycles k+1..k+9, high at k+10.
  - Required: busy high over the same cycles; shift_en low during the gap.
- Abort after 3 bits:
  - Required: FSM is in IDLE with load_ready=1 the cycle after abort.
  - Required: no cap_valid; cap_data keeps its prior value; bit_cnt=0.
- Abort coincident with the final shift cycle: no cap_valid, and a return to IDLE.
- Mid-transfer reset, then a normal transfer of 6'h3F:
  - Required after reset: all outputs 0 and load_ready low while rst is high.
  - Required: the next transfer completes correctly with no residue from the aborted word.
